// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder slice.
// The optional misaligned-access check is enabled by defining MEM_MISALIGN_CHECK_EN.
package mem_pkg;

   localparam int MEM_WORD_W  = 32;
   localparam int MEM_LAT_MAX = 15;
   localparam int MEM_CNT_W   = 4;
   localparam int MEM_STRB_W  = MEM_WORD_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   // Byte-lane merge used by the storage array on a partial store.
   function automatic logic [MEM_WORD_W-1:0] merge_bytes(
      input logic [MEM_WORD_W-1:0] old_word,
      input logic [MEM_WORD_W-1:0] new_word,
      input logic [MEM_STRB_W-1:0] strb
   );
      logic [MEM_WORD_W-1:0] res;
      res = old_word;
      for (int b = 0; b < MEM_STRB_W; b++) begin
         if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage with byte-write enables and a registered read port.
// Contents are never reset; only the read register clears under reset.
module mem_word_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic                  zero_i,
   input  logic [ADDR_W-1:0]     idx_i,
   input  logic [MEM_WORD_W-1:0] wdata_i,
   input  logic [MEM_STRB_W-1:0] wstrb_i,
   output logic [MEM_WORD_W-1:0] rdata_o
);

   logic [MEM_WORD_W-1:0] mem_q [2**ADDR_W];
   logic [MEM_WORD_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_ni && en_i && we_i) begin
         mem_q[idx_i] <= merge_bytes(mem_q[idx_i], wdata_i, wstrb_i);
      end
   end

   // Stores and suppressed accesses return zero instead of the stored word.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (en_i) begin
         rdata_q <= (we_i || zero_i) ? '0 : mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-outstanding memory responder with valid/ready request and response channels.
// Define MEM_MISALIGN_CHECK_EN to flag accesses whose addr[1:0] is non-zero.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [MEM_WORD_W-1:0] req_wdata,
   input  logic [MEM_STRB_W-1:0] req_wstrb,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [MEM_WORD_W-1:0] resp_rdata,
   output logic                  resp_err,
   output mem_state_e            dbg_state_o
);

   // Handshake: a transfer happens on an edge where valid and ready are both 1;
   // req_ready only in IDLE, resp_valid only in RESP, data held until consumed.

   localparam logic [MEM_CNT_W-1:0] LAT_M1 = MEM_CNT_W'(LATENCY - 1);
   localparam bit                   DIRECT = (LATENCY == 1);

   mem_state_e            state_q, state_d;
   logic [MEM_CNT_W-1:0]  cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [MEM_WORD_W-1:0] wdata_q;
   logic [MEM_STRB_W-1:0] wstrb_q;
   logic                  write_q;

   logic                  accept;
   logic                  commit;
   logic                  in_idle;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [MEM_WORD_W-1:0] acc_wdata;
   logic [MEM_STRB_W-1:0] acc_wstrb;
   logic                  acc_write;
   logic                  acc_err;
   logic                  unused_addr_bits;

   assign in_idle    = (state_q == ST_IDLE);
   assign req_ready  = reset && in_idle;
   assign resp_valid = (state_q == ST_RESP);
   assign accept     = req_valid && req_ready;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d   = LAT_M1;
               state_d = DIRECT ? ST_RESP : ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - MEM_CNT_W'(1);
            if (cnt_q == MEM_CNT_W'(1)) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_valid && resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q   <= req_addr[DEPTH_LOG2+1:2];
         wdata_q <= req_wdata;
         wstrb_q <= req_wstrb;
         write_q <= req_write;
      end
   end

   // With LATENCY=1 the access happens on the acceptance edge, so it uses the live request.
   assign acc_idx   = in_idle ? req_addr[DEPTH_LOG2+1:2] : idx_q;
   assign acc_wdata = in_idle ? req_wdata : wdata_q;
   assign acc_write = in_idle ? req_write : write_q;
   assign commit    = reset &&
                      ((in_idle && accept && DIRECT) ||
                       ((state_q == ST_BUSY) && (cnt_q == MEM_CNT_W'(1))));

`ifdef MEM_MISALIGN_CHECK_EN
   logic [1:0] lo_q;
   logic       err_q;

   always_ff @(posedge clk) begin
      if (accept) lo_q <= req_addr[1:0];
   end

   assign acc_err = in_idle ? (req_addr[1:0] != 2'b00) : (lo_q != 2'b00);

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (commit) begin
         err_q <= acc_err;
      end
   end

   assign resp_err         = err_q;
   assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];
`else
   assign acc_err          = 1'b0;
   assign resp_err         = 1'b0;
   assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};
`endif

   // A flagged access keeps its store from landing by dropping all byte enables.
   assign acc_wstrb = acc_err ? '0 : (in_idle ? req_wstrb : wstrb_q);

   mem_word_array #(
      .ADDR_W (DEPTH_LOG2)
   ) u_array (
      .clk_i   (clk),
      .rst_ni  (reset),
      .en_i    (commit),
      .we_i    (acc_write),
      .zero_i  (acc_err),
      .idx_i   (acc_idx),
      .wdata_i (acc_wdata),
      .wstrb_i (acc_wstrb),
      .rdata_o (resp_rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=3, one at LATENCY=1.
// Expectations follow MEM_MISALIGN_CHECK_EN when it is defined for the build.
module tb_mem_responder;
   import mem_pkg::*;

   logic        clk;
   logic        reset;

   logic        req_valid_a, req_ready_a, req_write_a;
   logic [31:0] req_addr_a, req_wdata_a;
   logic [3:0]  req_wstrb_a;
   logic        resp_valid_a, resp_ready_a, resp_err_a;
   logic [31:0] resp_rdata_a;
   mem_state_e  dbg_state_a;

   logic        req_valid_b, req_ready_b, req_write_b;
   logic [31:0] req_addr_b, req_wdata_b;
   logic [3:0]  req_wstrb_b;
   logic        resp_valid_b, resp_ready_b, resp_err_b;
   logic [31:0] resp_rdata_b;
   mem_state_e  dbg_state_b;

   int tests_run = 0;
   int tests_failed = 0;

   mem_responder #(.DEPTH_LOG2(12), .LATENCY(3)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
      .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_wstrb(req_wstrb_a),
      .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
      .resp_rdata(resp_rdata_a), .resp_err(resp_err_a), .dbg_state_o(dbg_state_a)
   );

   mem_responder #(.DEPTH_LOG2(12), .LATENCY(1)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_wstrb(req_wstrb_b),
      .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
      .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .dbg_state_o(dbg_state_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the LATENCY=3 instance; hold = cycles resp_ready stays low in RESP.
   task automatic req_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold, input string tag);
      int lat;
      chk({tag, " ready_idle"}, 32'(req_ready_a), 32'd1);
      req_valid_a = 1'b1;
      req_write_a = wr;
      req_addr_a  = addr;
      req_wdata_a = wdata;
      req_wstrb_a = strb;
      tick();
      req_valid_a = 1'b0;
      lat = 1;
      while (!resp_valid_a && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'd3);
      chk({tag, " rdata"}, resp_rdata_a, exp_rdata);
      chk({tag, " err"}, 32'(resp_err_a), 32'(exp_err));
      chk({tag, " ready_busy"}, 32'(req_ready_a), 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, " hold_valid"}, 32'(resp_valid_a), 32'd1);
         chk({tag, " hold_rdata"}, resp_rdata_a, exp_rdata);
         chk({tag, " hold_ready"}, 32'(req_ready_a), 32'd0);
      end
      resp_ready_a = 1'b1;
      tick();
      resp_ready_a = 1'b0;
      chk({tag, " valid_drop"}, 32'(resp_valid_a), 32'd0);
      chk({tag, " ready_back"}, 32'(req_ready_a), 32'd1);
   endtask

   initial begin
      reset = 1'b0;
      req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; req_wstrb_a = '0;
      resp_ready_a = 1'b0;
      req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; req_wstrb_b = '0;
      resp_ready_b = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst ready", 32'(req_ready_a), 32'd0);
      chk("rst valid", 32'(resp_valid_a), 32'd0);
      chk("rst rdata", resp_rdata_a, 32'd0);
      chk("rst err", 32'(resp_err_a), 32'd0);
      chk("rst state", 32'(dbg_state_a), 32'(ST_IDLE));
      reset = 1'b1;
      tick();
      chk("rel ready", 32'(req_ready_a), 32'd1);

      // Full store, load, partial store, load with a held response, wrap-around alias
      req_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0, "st_full");
      req_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, "ld_full");
      req_a(1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, 0, "st_byte0");
      req_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 5, "ld_hold");
      req_a(1'b0, 32'h4010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0, "ld_wrap");

      // Zero strobe still responds and leaves the word alone
      req_a(1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0, 0, "st_nostrb");
      req_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0, "ld_nostrb");

      // Middle byte lanes
      req_a(1'b1, 32'h24, 32'h0, 4'hF, 32'h0, 1'b0, 0, "st_clr24");
      req_a(1'b1, 32'h24, 32'hAABBCCDD, 4'h6, 32'h0, 1'b0, 0, "st_mid24");
      req_a(1'b0, 32'h24, 32'h0, 4'h0, 32'h00BBCC00, 1'b0, 0, "ld_mid24");

      // Reset landing on the commit edge abandons the store
      req_a(1'b1, 32'h20, 32'h11112222, 4'hF, 32'h0, 1'b0, 0, "st_old20");
      req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'h20;
      req_wdata_a = 32'h33334444; req_wstrb_a = 4'hF;
      tick();
      req_valid_a = 1'b0;
      chk("abort busy", 32'(dbg_state_a), 32'(ST_BUSY));
      tick();
      chk("abort still_busy", 32'(dbg_state_a), 32'(ST_BUSY));
      reset = 1'b0;
      #1;
      chk("abort ready_low", 32'(req_ready_a), 32'd0);
      tick();
      chk("abort idle", 32'(dbg_state_a), 32'(ST_IDLE));
      chk("abort valid", 32'(resp_valid_a), 32'd0);
      chk("abort rdata", resp_rdata_a, 32'd0);
      reset = 1'b1;
      tick();
      req_a(1'b0, 32'h20, 32'h0, 4'h0, 32'h11112222, 1'b0, 0, "ld_old20");

      // Misaligned store
`ifdef MEM_MISALIGN_CHECK_EN
      req_a(1'b1, 32'h13, 32'h55667788, 4'hF, 32'h0, 1'b1, 0, "st_mis");
      req_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0, "ld_mis");
`else
      req_a(1'b1, 32'h13, 32'h55667788, 4'hF, 32'h0, 1'b0, 0, "st_mis");
      req_a(1'b0, 32'h10, 32'h0, 4'h0, 32'h55667788, 1'b0, 0, "ld_mis");
`endif

      // LATENCY=1: store, then back-to-back loads with resp_ready held high
      resp_ready_b = 1'b1;
      chk("b ready", 32'(req_ready_b), 32'd1);
      req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 32'h10;
      req_wdata_b = 32'h12345678; req_wstrb_b = 4'hF;
      tick();
      chk("b st valid", 32'(resp_valid_b), 32'd1);
      chk("b st rdata", resp_rdata_b, 32'd0);
      req_write_b = 1'b0;
      tick();
      chk("b st done", 32'(resp_valid_b), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("b ld%0d valid", i), 32'(resp_valid_b), 32'd1);
         chk($sformatf("b ld%0d rdata", i), resp_rdata_b, 32'h12345678);
         chk($sformatf("b ld%0d ready", i), 32'(req_ready_b), 32'd0);
         tick();
         chk($sformatf("b ld%0d gap", i), 32'(resp_valid_b), 32'd0);
         chk($sformatf("b ld%0d reready", i), 32'(req_ready_b), 32'd1);
      end
      req_valid_b = 1'b0;
      resp_ready_b = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 12, log2 of the number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 3, number of clock edges from request acceptance to the first resp_valid cycle; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_wstrb  input  4  store byte enables; bit i enables byte i.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator consumes the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores.
REQ-014 resp_err  output  1  error flag for the response (see Configuration).

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-017 In IDLE, req_valid&req_ready SHALL latch addr, wdata, wstrb and write, and load the latency counter with LATENCY-1.
REQ-018 On acceptance the FSM SHALL go to BUSY if LATENCY>1, else directly to RESP.
REQ-019 In BUSY the counter SHALL decrement each cycle; the transition to RESP SHALL occur on the edge where the counter equals 1. resp_valid therefore first asserts exactly LATENCY cycles after the acceptance edge.
REQ-020 Word index SHALL be addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-021 A store SHALL commit only its enabled bytes, on the edge entering RESP; wstrb=0 SHALL leave memory unchanged and still produce a response.
REQ-022 resp_rdata SHALL be registered on the edge entering RESP and held stable while resp_valid=1.
REQ-023 In RESP, resp_valid&resp_ready SHALL return the FSM to IDLE; otherwise it SHALL remain in RESP indefinitely.
REQ-024 No request SHALL be accepted in BUSY or RESP; the minimum spacing between accepted requests is LATENCY+1 cycles.
REQ-025 A load of a word stored by the immediately preceding transaction SHALL return the new data.

Reset
REQ-026 While reset=0 at an edge, the FSM SHALL enter IDLE, the counter SHALL clear to 0, resp_rdata SHALL clear to 0 and resp_err SHALL clear to 0.
REQ-027 req_ready SHALL be 0 in any cycle where reset=0 and 1 in the first cycle after release.
REQ-028 A reset during BUSY or RESP SHALL abandon the transaction; a store SHALL not commit if reset=0 on its commit edge.
REQ-029 Memory contents SHALL NOT be reset.

Configuration
REQ-030 With macro MEM_MISALIGN_CHECK_EN defined: addr[1:0]!=0 SHALL suppress the store commit, force resp_rdata=0 and set resp_err=1 for that response.
REQ-031 Without MEM_MISALIGN_CHECK_EN: addr[1:0] SHALL be ignored and resp_err SHALL be constant 0.

Structure
REQ-032 Package mem_pkg SHALL hold the FSM state enum, MEM_WORD_W=32 and MEM_LAT_MAX=15.
REQ-033 Storage SHALL be a sub-module mem_word_array: one synchronous read/write port with byte-write enables.

Verification
REQ-034 LATENCY=3: store 0xDEADBEEF at 0x10 with wstrb=0xF, accepted at edge N -> resp_valid first high in cycle N+3, resp_rdata=0.
REQ-035 Load 0x10 -> 0xDEADBEEF. Store 0x000000AA at 0x10 with wstrb=0x1, then load 0x10 -> 0xDEADBEAA.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable and req_ready=0 throughout; one cycle after resp_ready=1, req_ready=1.
REQ-037 LATENCY=1: back-to-back loads -> each response appears 1 cycle after acceptance; requests accepted every 2 cycles.
REQ-038 Assert reset=0 during BUSY of a store to 0x20 -> next state IDLE and a subsequent load of 0x20 returns the old value; with DEPTH_LOG2=12, a load of 0x4010 returns the word at 0x10.
REQ-039 With MEM_MISALIGN_CHECK_EN, store to 0x13 -> resp_err=1 and memory unchanged; without the macro, the same store writes the word at 0x10 and resp_err=0.
